// File: rtl/spi_resp_tx.sv
// SPI-slave response transmitter: double-buffered {tag,data} word shifted out MSB first
// on MISO (mode 0) during each SS_n frame, with done/abort/underrun status pulses.
module spi_resp_tx #(
  parameter int                          DATA_W    = 12,
  parameter int                          TAG_W     = 4,
  parameter logic [DATA_W+TAG_W-1:0]     FILL_WORD = 16'hFA5A
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic [TAG_W-1:0]  i_tx_tag,
  input  logic              i_tx_load,
  output logic              o_tx_ready,
  input  logic              i_sclk,
  input  logic              i_ss_n,
  output logic              o_miso,
  output logic              o_tx_done,
  output logic              o_tx_abort,
  output logic              o_tx_underrun
);

  localparam int                W        = DATA_W + TAG_W;
  localparam int                CNT_W    = $clog2(W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(W);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           r_state;
  logic             r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic             r_ss_s1, r_ss_s2, r_ss_d;
  logic [W-1:0]     r_buf;
  logic             r_buf_valid;
  logic [W-1:0]     r_shift;
  logic [CNT_W-1:0] r_bit_cnt;

  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_ss_fall   = ~r_ss_s2 & r_ss_d;
  assign w_ss_rise   = r_ss_s2 & ~r_ss_d;

  assign o_tx_ready = ~r_buf_valid;
  // The SS_n chain resets low, so MISO is also released explicitly while reset is held.
  assign o_miso     = (i_rst | r_ss_s2) ? 1'bz : r_shift[W-1];

  // Both chains reset to 0 so a master already deselected at reset release looks like an SS_n rise, never a fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_ss_s1   <= 1'b0;
      r_ss_s2   <= 1'b0;
      r_ss_d    <= 1'b0;
    end else begin
      r_sclk_s1 <= i_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_ss_s1   <= i_ss_n;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_buf         <= '0;
      r_buf_valid   <= 1'b0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      o_tx_done     <= 1'b0;
      o_tx_abort    <= 1'b0;
      o_tx_underrun <= 1'b0;
    end else begin
      o_tx_done     <= 1'b0;
      o_tx_abort    <= 1'b0;
      o_tx_underrun <= 1'b0;

      if (i_tx_load && !r_buf_valid) begin
        r_buf       <= {i_tx_tag, i_tx_data};
        r_buf_valid <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_state   <= ST_SHIFT;
            r_bit_cnt <= '0;
            if (r_buf_valid) begin
              r_shift     <= r_buf;
              r_buf_valid <= 1'b0;
            end else begin
              // A load arriving this same cycle is kept for the next frame.
              r_shift       <= FILL_WORD;
              o_tx_underrun <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (w_ss_rise) begin
            r_state <= ST_IDLE;
            if (r_bit_cnt == CNT_FULL) o_tx_done  <= 1'b1;
            else                       o_tx_abort <= 1'b1;
          end else if (w_sclk_rise) begin
            if (r_bit_cnt != CNT_FULL) r_bit_cnt <= r_bit_cnt + 1'b1;
          end else if (w_sclk_fall) begin
            r_shift <= {r_shift[W-2:0], 1'b0};
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
